wb_regwr: RTL

Write-back collector that sits in stage 5 and owns the single write port of the integer register file. It accepts completed results from the single-cycle ALU path and the multi-cycle load path, queues them in program order in a small FIFO, and retires one result per cycle as a registered write strobe. When compiled in, it also forwards values that are pending but not yet written to the decode-stage read ports.

---
 rtl/wb_regwr_if.sv | 39 +++
 rtl/wb_regwr.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/wb_regwr_if.sv
// Bundle of the write-back collector's bus signals: ALU/load result inputs,
// the register-file write strobe and the decode-stage forwarding ports.
interface wb_regwr_if;
  logic        i_aluValid;
  logic [4:0]  i_aluReg;
  logic [31:0] i_aluData;
  logic        i_ldValid;
  logic        o_ldReady;
  logic [4:0]  i_ldReg;
  logic [31:0] i_ldData;
  logic        o_stall;
  logic        o_wrSig;
  logic [4:0]  o_wrReg;
  logic [31:0] o_wrData;
  logic [4:0]  i_rdReg1;
  logic [4:0]  i_rdReg2;
  logic        o_fwdHit1;
  logic        o_fwdHit2;
  logic [31:0] o_fwdData1;
  logic [31:0] o_fwdData2;

  modport slave (
    input  i_aluValid, i_aluReg, i_aluData,
    input  i_ldValid, i_ldReg, i_ldData,
    input  i_rdReg1, i_rdReg2,
    output o_ldReady, o_stall,
    output o_wrSig, o_wrReg, o_wrData,
    output o_fwdHit1, o_fwdHit2, o_fwdData1, o_fwdData2
  );

  modport master (
    output i_aluValid, i_aluReg, i_aluData,
    output i_ldValid, i_ldReg, i_ldData,
    output i_rdReg1, i_rdReg2,
    input  o_ldReady, o_stall,
    input  o_wrSig, o_wrReg, o_wrData,
    input  o_fwdHit1, o_fwdHit2, o_fwdData1, o_fwdData2
  );
endinterface

// File: rtl/wb_regwr.sv
// Stage-5 write-back collector: in-order FIFO of ALU/load results, one
// registered register-file write per cycle. Define WB_FWD_EN for forwarding.
module wb_regwr #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  wb_regwr_if.slave  bus
);
  // Handshakes: the ALU source has no backpressure and must stay idle while
  // o_stall=1; a load transfers on any cycle where i_ldValid & o_ldReady.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0] r_count;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [4:0]    r_mem_reg  [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic          r_wr_sig;
  logic [4:0]    r_wr_reg;
  logic [31:0]   r_wr_data;

  logic          w_pop;
  logic          w_stall;
  logic          w_alu_nz;
  logic          w_alu_store;
  logic          w_ld_ready;
  logic          w_ld_store;
  logic [CW:0]   w_ld_level;
  logic [PW-1:0] w_alu_addr;
  logic [PW-1:0] w_tail_nxt;
  logic [CW-1:0] w_count_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign w_pop      = (r_count != '0);
  assign w_stall    = (r_count >= CW'(DEPTH - 1));
  assign w_alu_nz   = bus.i_aluValid && (bus.i_aluReg != 5'd0);
  assign w_ld_level = {1'b0, r_count} + {{CW{1'b0}}, w_alu_nz} - {{CW{1'b0}}, w_pop};
  assign w_ld_ready = (w_ld_level < (CW+1)'(DEPTH));

  // Results to x0 complete their handshake but never occupy an entry.
  assign w_ld_store  = bus.i_ldValid && w_ld_ready && (bus.i_ldReg != 5'd0);
  assign w_alu_store = w_alu_nz && !w_stall;

  // The load is older than a same-cycle ALU result, so it takes the tail slot.
  assign w_alu_addr  = w_ld_store ? ptr_inc(r_tail) : r_tail;
  assign w_tail_nxt  = w_alu_store ? ptr_inc(w_alu_addr)
                     : (w_ld_store ? ptr_inc(r_tail) : r_tail);
  assign w_count_nxt = r_count + CW'(w_ld_store) + CW'(w_alu_store) - CW'(w_pop);

  always_ff @(posedge i_clk) begin
    if (w_ld_store) begin
      r_mem_reg[r_tail]  <= bus.i_ldReg;
      r_mem_data[r_tail] <= bus.i_ldData;
    end
    if (w_alu_store) begin
      r_mem_reg[w_alu_addr]  <= bus.i_aluReg;
      r_mem_data[w_alu_addr] <= bus.i_aluData;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_wr_sig  <= 1'b0;
      r_wr_reg  <= 5'd0;
      r_wr_data <= 32'd0;
    end else begin
      r_count  <= w_count_nxt;
      r_tail   <= w_tail_nxt;
      r_wr_sig <= w_pop;
      if (w_pop) begin
        r_head    <= ptr_inc(r_head);
        r_wr_reg  <= r_mem_reg[r_head];
        r_wr_data <= r_mem_data[r_head];
      end
    end
  end

  assign bus.o_ldReady = w_ld_ready;
  assign bus.o_stall   = w_stall;
  assign bus.o_wrSig   = r_wr_sig;
  assign bus.o_wrReg   = r_wr_reg;
  assign bus.o_wrData  = r_wr_data;

`ifdef WB_FWD_EN
  logic        w_hit1;
  logic        w_hit2;
  logic [31:0] w_fwd1;
  logic [31:0] w_fwd2;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx  = '0;
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_fwd1 = 32'd0;
    w_fwd2 = 32'd0;
    if (r_wr_sig && (r_wr_reg == bus.i_rdReg1)) begin
      w_hit1 = 1'b1;
      w_fwd1 = r_wr_data;
    end
    if (r_wr_sig && (r_wr_reg == bus.i_rdReg2)) begin
      w_hit2 = 1'b1;
      w_fwd2 = r_wr_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(r_count)) begin
        v_idx = PW'((int'(r_head) + i) % DEPTH);
        if (r_mem_reg[v_idx] == bus.i_rdReg1) begin
          w_hit1 = 1'b1;
          w_fwd1 = r_mem_data[v_idx];
        end
        if (r_mem_reg[v_idx] == bus.i_rdReg2) begin
          w_hit2 = 1'b1;
          w_fwd2 = r_mem_data[v_idx];
        end
      end
    end
    // x0 is hardwired; a stale match on index 0 must never forward.
    if (bus.i_rdReg1 == 5'd0) begin
      w_hit1 = 1'b0;
      w_fwd1 = 32'd0;
    end
    if (bus.i_rdReg2 == 5'd0) begin
      w_hit2 = 1'b0;
      w_fwd2 = 32'd0;
    end
  end

  assign bus.o_fwdHit1  = w_hit1;
  assign bus.o_fwdHit2  = w_hit2;
  assign bus.o_fwdData1 = w_fwd1;
  assign bus.o_fwdData2 = w_fwd2;
`else
  logic w_unused_rd;
  assign w_unused_rd    = ^{bus.i_rdReg1, bus.i_rdReg2};
  assign bus.o_fwdHit1  = 1'b0;
  assign bus.o_fwdHit2  = 1'b0;
  assign bus.o_fwdData1 = 32'd0;
  assign bus.o_fwdData2 = 32'd0;
`endif

  a_alu_while_stalled: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(bus.i_aluValid && w_stall))
    else $error("wb_regwr: ALU result issued while stalled, entry dropped");

endmodule
